// File: rtl/ifmem_bus_arbiter_if.sv
// Signal bundle shared by the IF/MEM requesters, the IF/MEM bus arbiter and the system-bus slave.
// "slave" is the arbiter's view; "master" is the view of whoever drives requests and models the bus slave.
interface ifmem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_ack_o;
   logic              if_err_o;
   logic              mem_req_i;
   logic              mem_we_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [DATA_W-1:0] mem_wdata_i;
   logic [3:0]        mem_sel_i;
   logic [DATA_W-1:0] mem_rdata_o;
   logic              mem_ack_o;
   logic              mem_err_o;
   logic              flush_i;
   logic              bus_req_o;
   logic              bus_we_o;
   logic [ADDR_W-1:0] bus_addr_o;
   logic [DATA_W-1:0] bus_wdata_o;
   logic [3:0]        bus_sel_o;
   logic              bus_ack_i;
   logic [DATA_W-1:0] bus_rdata_i;
   logic              stallreq_if_o;
   logic              stallreq_mem_o;

   modport slave (
      input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
             flush_i, bus_ack_i, bus_rdata_i,
      output if_rdata_o, if_ack_o, if_err_o, mem_rdata_o, mem_ack_o, mem_err_o,
             bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
             stallreq_if_o, stallreq_mem_o
   );

   modport master (
      output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
             flush_i, bus_ack_i, bus_rdata_i,
      input  if_rdata_o, if_ack_o, if_err_o, mem_rdata_o, mem_ack_o, mem_err_o,
             bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
             stallreq_if_o, stallreq_mem_o
   );
endinterface

// File: rtl/ifmem_bus_arbiter.sv
// Shares the single system-bus master port between instruction fetch and data access,
// one outstanding transfer at a time, with timeout abort and fetch-result discard on flush.
module ifmem_bus_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input logic                clk,
   input logic                rst,
   ifmem_bus_arbiter_if.slave arb
);
   typedef enum logic [1:0] {IDLE, IF_XFER, MEM_XFER} state_t;

   localparam logic [15:0]       TO_LAST   = 16'(TIMEOUT_CYC - 1);
   localparam logic [DATA_W-1:0] ZERO_DATA = '0;

   state_t            state;
   state_t            state_next;
   logic              discard;
   logic              fair_if;
   logic [15:0]       wait_cnt;
   logic              bus_req_q;
   logic              bus_we_q;
   logic [ADDR_W-1:0] bus_addr_q;
   logic [DATA_W-1:0] bus_wdata_q;
   logic [3:0]        bus_sel_q;
   logic              in_xfer;
   logic              bus_done;
   logic              timed_out;
   logic              xfer_end;
   logic              grant_mem;
   logic              grant_if;
   logic              kill_fetch;
   logic              if_ack;
   logic              if_err;
   logic              mem_ack;
   logic              mem_err;
   logic [ADDR_W-1:0] addr_next;
   logic [DATA_W-1:0] wdata_next;
   logic [3:0]        sel_next;
   logic              we_next;

   assign in_xfer    = (state != IDLE);
   assign bus_done   = in_xfer & arb.bus_ack_i;
   assign timed_out  = in_xfer & ~arb.bus_ack_i & (wait_cnt == TO_LAST);
   assign xfer_end   = bus_done | timed_out;
   // MEM wins unless the previous MEM transfer ended while IF was already waiting.
   assign grant_mem  = arb.mem_req_i & ~(fair_if & arb.if_req_i);
   assign grant_if   = ~grant_mem & arb.if_req_i;
   assign kill_fetch = discard | arb.flush_i;

   assign addr_next  = grant_mem ? arb.mem_addr_i  : arb.if_addr_i;
   assign wdata_next = grant_mem ? arb.mem_wdata_i : ZERO_DATA;
   assign sel_next   = grant_mem ? arb.mem_sel_i   : 4'b1111;
   assign we_next    = grant_mem & arb.mem_we_i;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_mem) begin
               state_next = MEM_XFER;
            end else if (grant_if) begin
               state_next = IF_XFER;
            end
         end
         IF_XFER, MEM_XFER: begin
            if (xfer_end) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Completion pulses are gated by reset so an abandoned transfer never reports back.
   always_comb begin
      if_ack  = 1'b0;
      if_err  = 1'b0;
      mem_ack = 1'b0;
      mem_err = 1'b0;
      if (rst) begin
         case (state)
            IF_XFER: begin
               if_ack = arb.bus_ack_i & ~kill_fetch;
               if_err = timed_out & ~kill_fetch;
            end
            MEM_XFER: begin
               mem_ack = arb.bus_ack_i;
               mem_err = timed_out;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_sel_q   <= '0;
         discard     <= 1'b0;
         fair_if     <= 1'b0;
         wait_cnt    <= '0;
      end else if (state == IDLE) begin
         wait_cnt <= '0;
         discard  <= grant_if & arb.flush_i;
         if (grant_mem | grant_if) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= we_next;
            bus_addr_q  <= addr_next;
            bus_wdata_q <= wdata_next;
            bus_sel_q   <= sel_next;
         end
         if (grant_if) begin
            fair_if <= 1'b0;
         end
      end else if (xfer_end) begin
         bus_req_q <= 1'b0;
         discard   <= 1'b0;
         if ((state == MEM_XFER) && arb.if_req_i) begin
            fair_if <= 1'b1;
         end
      end else begin
         wait_cnt <= wait_cnt + 16'd1;
         if ((state == IF_XFER) && arb.flush_i) begin
            discard <= 1'b1;
         end
      end
   end

   assign arb.bus_req_o      = bus_req_q;
   assign arb.bus_we_o       = bus_we_q;
   assign arb.bus_addr_o     = bus_addr_q;
   assign arb.bus_wdata_o    = bus_wdata_q;
   assign arb.bus_sel_o      = bus_sel_q;
   assign arb.if_ack_o       = if_ack;
   assign arb.if_err_o       = if_err;
   assign arb.if_rdata_o     = if_ack ? arb.bus_rdata_i : ZERO_DATA;
   assign arb.mem_ack_o      = mem_ack;
   assign arb.mem_err_o      = mem_err;
   assign arb.mem_rdata_o    = mem_ack ? arb.bus_rdata_i : ZERO_DATA;
   assign arb.stallreq_if_o  = arb.if_req_i & ~if_ack;
   assign arb.stallreq_mem_o = arb.mem_req_i & ~mem_ack;
endmodule

// File: tb/tb_ifmem_bus_arbiter.sv
// Directed bench for the IF/MEM bus arbiter: a per-cycle vector table plus hand-written
// sequences for timeout, reset mid-transfer and sustained contention.
module tb_ifmem_bus_arbiter;
   typedef struct {
      logic        rst;
      logic        if_req;
      logic [31:0] if_addr;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_sel;
      logic        flush;
      logic        bus_ack;
      logic [31:0] bus_rdata;
   } stim_t;

   typedef struct {
      logic        bus_req;
      logic        bus_we;
      logic [31:0] bus_addr;
      logic [3:0]  bus_sel;
      logic        if_ack;
      logic        if_err;
      logic [31:0] if_rdata;
      logic        mem_ack;
      logic        mem_err;
      logic [31:0] mem_rdata;
      logic        stall_if;
      logic        stall_mem;
   } expect_t;

   typedef struct {
      stim_t   s;
      expect_t e;
   } vec_t;

   localparam logic        L     = 1'b0;
   localparam logic        H     = 1'b1;
   localparam logic [31:0] Z     = 32'h0;
   localparam logic [31:0] WDATA = 32'hCAFE0001;
   localparam logic [3:0]  MSEL  = 4'h3;
   localparam logic [3:0]  F4    = 4'hF;
   localparam logic [3:0]  N4    = 4'h0;
   localparam logic [31:0] IA    = 32'h0000_0100;
   localparam logic [31:0] MA    = 32'h0000_4000;
   localparam logic [31:0] IA2   = 32'h0000_0400;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   vec_t vecs[$];

   ifmem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) arb_bus ();

   ifmem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
      .clk (clk),
      .rst (rst),
      .arb (arb_bus)
   );

   always #5 clk = ~clk;

   function automatic stim_t st(logic r, logic ifq, logic [31:0] ifa, logic memq, logic we,
                                logic [31:0] mema, logic fl, logic ack, logic [31:0] rd);
      stim_t s;
      s.rst       = r;
      s.if_req    = ifq;
      s.if_addr   = ifa;
      s.mem_req   = memq;
      s.mem_we    = we;
      s.mem_addr  = mema;
      s.mem_wdata = WDATA;
      s.mem_sel   = MSEL;
      s.flush     = fl;
      s.bus_ack   = ack;
      s.bus_rdata = rd;
      return s;
   endfunction

   function automatic expect_t ex(logic breq, logic bwe, logic [31:0] baddr, logic [3:0] bsel,
                                  logic ifack, logic iferr, logic [31:0] ifrd,
                                  logic memack, logic memerr, logic [31:0] memrd,
                                  logic stif, logic stmem);
      expect_t e;
      e.bus_req   = breq;
      e.bus_we    = bwe;
      e.bus_addr  = baddr;
      e.bus_sel   = bsel;
      e.if_ack    = ifack;
      e.if_err    = iferr;
      e.if_rdata  = ifrd;
      e.mem_ack   = memack;
      e.mem_err   = memerr;
      e.mem_rdata = memrd;
      e.stall_if  = stif;
      e.stall_mem = stmem;
      return e;
   endfunction

   task automatic addVec(input stim_t s, input expect_t e);
      vec_t v;
      v.s = s;
      v.e = e;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input stim_t s);
      rst                 = s.rst;
      arb_bus.if_req_i    = s.if_req;
      arb_bus.if_addr_i   = s.if_addr;
      arb_bus.mem_req_i   = s.mem_req;
      arb_bus.mem_we_i    = s.mem_we;
      arb_bus.mem_addr_i  = s.mem_addr;
      arb_bus.mem_wdata_i = s.mem_wdata;
      arb_bus.mem_sel_i   = s.mem_sel;
      arb_bus.flush_i     = s.flush;
      arb_bus.bus_ack_i   = s.bus_ack;
      arb_bus.bus_rdata_i = s.bus_rdata;
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0b exp=%0b", name, act, exp);
      end
   endtask

   task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input expect_t e);
      checkBit({tag, " bus_req"}, arb_bus.bus_req_o, e.bus_req);
      if (e.bus_req) begin
         checkBit({tag, " bus_we"}, arb_bus.bus_we_o, e.bus_we);
         checkWord({tag, " bus_addr"}, arb_bus.bus_addr_o, e.bus_addr);
         checkWord({tag, " bus_sel"}, {28'h0, arb_bus.bus_sel_o}, {28'h0, e.bus_sel});
         if (e.bus_we) begin
            checkWord({tag, " bus_wdata"}, arb_bus.bus_wdata_o, WDATA);
         end
      end
      checkBit({tag, " if_ack"}, arb_bus.if_ack_o, e.if_ack);
      checkBit({tag, " if_err"}, arb_bus.if_err_o, e.if_err);
      checkWord({tag, " if_rdata"}, arb_bus.if_rdata_o, e.if_rdata);
      checkBit({tag, " mem_ack"}, arb_bus.mem_ack_o, e.mem_ack);
      checkBit({tag, " mem_err"}, arb_bus.mem_err_o, e.mem_err);
      checkWord({tag, " mem_rdata"}, arb_bus.mem_rdata_o, e.mem_rdata);
      checkBit({tag, " stall_if"}, arb_bus.stallreq_if_o, e.stall_if);
      checkBit({tag, " stall_mem"}, arb_bus.stallreq_mem_o, e.stall_mem);
   endtask

   task automatic doCycle(input string tag, input stim_t s, input expect_t e);
      @(posedge clk);
      #1 applyStimulus(s);
      @(negedge clk);
      checkOutput(tag, e);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset held three edges with both requesters active, then MEM wins the first grant.
      addVec(st(L,H,IA,H,H,MA,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, H,H));
      addVec(st(L,H,IA,H,H,MA,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, H,H));
      addVec(st(L,H,IA,H,H,MA,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, H,H));
      addVec(st(H,H,IA,H,H,MA,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, H,H));
      addVec(st(H,H,IA,H,H,MA,L,L,Z), ex(H,H,MA,MSEL, L,L,Z, L,L,Z, H,H));
      addVec(st(H,H,IA,H,H,MA,L,H,32'h11112222), ex(H,H,MA,MSEL, L,L,Z, H,L,32'h11112222, H,L));
      // IF alone, slave acks three cycles after bus_req rises (the timeout boundary cycle).
      addVec(st(H,H,IA,L,L,MA,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, H,L));
      addVec(st(H,H,IA,L,L,MA,L,L,Z), ex(H,L,IA,F4, L,L,Z, L,L,Z, H,L));
      addVec(st(H,H,IA,L,L,MA,L,L,Z), ex(H,L,IA,F4, L,L,Z, L,L,Z, H,L));
      addVec(st(H,H,IA,L,L,MA,L,L,Z), ex(H,L,IA,F4, L,L,Z, L,L,Z, H,L));
      addVec(st(H,H,IA,L,L,MA,L,H,32'hDEADBEEF), ex(H,L,IA,F4, H,L,32'hDEADBEEF, L,L,Z, L,L));
      addVec(st(H,L,IA,L,L,MA,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, L,L));
      // Flush during an IF transfer swallows its ack; the next fetch is acked normally.
      addVec(st(H,H,32'h180,L,L,MA,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, H,L));
      addVec(st(H,H,32'h180,L,L,MA,H,L,Z), ex(H,L,32'h180,F4, L,L,Z, L,L,Z, H,L));
      addVec(st(H,H,32'h180,L,L,MA,L,H,32'h55AA55AA), ex(H,L,32'h180,F4, L,L,Z, L,L,Z, H,L));
      addVec(st(H,H,32'h200,L,L,MA,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, H,L));
      addVec(st(H,H,32'h200,L,L,MA,L,H,32'h0BADF00D), ex(H,L,32'h200,F4, H,L,32'h0BADF00D, L,L,Z, L,L));
      addVec(st(H,L,32'h200,L,L,MA,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, L,L));

      applyStimulus(vecs[0].s);
      for (int i = 0; i < vecs.size(); i++) begin
         doCycle($sformatf("vec%0d", i), vecs[i].s, vecs[i].e);
      end

      // MEM write that is never acked errors in its 4th bus cycle; a waiting IF is served next.
      doCycle("to0", st(H,L,IA2,H,H,32'h300,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, L,H));
      doCycle("to1", st(H,L,IA2,H,H,32'h300,L,L,Z), ex(H,H,32'h300,MSEL, L,L,Z, L,L,Z, L,H));
      doCycle("to2", st(H,H,IA2,H,H,32'h300,L,L,Z), ex(H,H,32'h300,MSEL, L,L,Z, L,L,Z, H,H));
      doCycle("to3", st(H,H,IA2,H,H,32'h300,L,L,Z), ex(H,H,32'h300,MSEL, L,L,Z, L,L,Z, H,H));
      doCycle("to4", st(H,H,IA2,H,H,32'h300,L,L,Z), ex(H,H,32'h300,MSEL, L,L,Z, L,H,Z, H,H));
      doCycle("to5", st(H,H,IA2,L,L,32'h300,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, H,L));
      doCycle("to6", st(H,H,IA2,L,L,32'h300,L,H,32'hA5A5A5A5), ex(H,L,IA2,F4, H,L,32'hA5A5A5A5, L,L,Z, L,L));
      doCycle("to7", st(H,L,IA2,L,L,32'h300,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, L,L));
      // Same write, ack lands on the timeout cycle: ack wins.
      doCycle("ta0", st(H,L,IA2,H,H,32'h304,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, L,H));
      doCycle("ta1", st(H,L,IA2,H,H,32'h304,L,L,Z), ex(H,H,32'h304,MSEL, L,L,Z, L,L,Z, L,H));
      doCycle("ta2", st(H,L,IA2,H,H,32'h304,L,L,Z), ex(H,H,32'h304,MSEL, L,L,Z, L,L,Z, L,H));
      doCycle("ta3", st(H,L,IA2,H,H,32'h304,L,L,Z), ex(H,H,32'h304,MSEL, L,L,Z, L,L,Z, L,H));
      doCycle("ta4", st(H,L,IA2,H,H,32'h304,L,H,32'h12345678), ex(H,H,32'h304,MSEL, L,L,Z, H,L,32'h12345678, L,L));
      doCycle("ta5", st(H,L,IA2,L,L,32'h304,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, L,L));

      // Reset in the middle of a MEM read: nothing reported, late ack ignored.
      doCycle("rm0", st(H,L,IA2,H,L,32'h500,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, L,H));
      doCycle("rm1", st(H,L,IA2,H,L,32'h500,L,L,Z), ex(H,L,32'h500,MSEL, L,L,Z, L,L,Z, L,H));
      doCycle("rm2", st(L,L,IA2,H,L,32'h500,L,H,32'h77777777), ex(H,L,32'h500,MSEL, L,L,Z, L,L,Z, L,H));
      doCycle("rm3", st(H,L,IA2,L,L,32'h500,L,H,32'h77777777), ex(L,L,Z,N4, L,L,Z, L,L,Z, L,L));
      doCycle("rm4", st(H,L,IA2,L,L,32'h500,L,L,Z), ex(L,L,Z,N4, L,L,Z, L,L,Z, L,L));

      // Both requesters held with a zero-wait slave: grants must alternate MEM, IF, MEM, IF.
      begin
         bit   grants[$];
         logic prev_req;
         applyStimulus(st(H,H,32'h600,H,L,32'h700,L,L,Z));
         prev_req = 1'b0;
         for (int cyc = 0; cyc < 20 && grants.size() < 4; cyc++) begin
            @(posedge clk);
            #1;
            arb_bus.bus_ack_i   = arb_bus.bus_req_o;
            arb_bus.bus_rdata_i = 32'(cyc);
            @(negedge clk);
            if (arb_bus.bus_req_o) begin
               checkBit($sformatf("cont%0d mem_ack", cyc), arb_bus.mem_ack_o, arb_bus.bus_addr_o == 32'h700);
               checkBit($sformatf("cont%0d if_ack", cyc), arb_bus.if_ack_o, arb_bus.bus_addr_o == 32'h600);
               if (!prev_req) begin
                  grants.push_back(arb_bus.bus_addr_o == 32'h700);
               end
            end
            prev_req = arb_bus.bus_req_o;
         end
         checkWord("cont grant_count", 32'(grants.size()), 32'd4);
         for (int i = 0; i < 4; i++) begin
            logic got_mem;
            got_mem = (i < grants.size()) ? grants[i] : 1'bx;
            checkBit($sformatf("cont grant%0d is_mem", i), got_mem, (i % 2) == 0);
         end
         @(posedge clk);
         #1;
         arb_bus.if_req_i  = 1'b0;
         arb_bus.mem_req_i = 1'b0;
         arb_bus.bus_ack_i = 1'b0;
         @(negedge clk);
         checkBit("cont drain bus_req", arb_bus.bus_req_o, L);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
